// File: rtl/ipv4_pkg.sv
// ipv4_pkg
//   Shared constants, header field bundle and FSM state encoding for the
//   IPv4 header inserter and its checksum generator.
package ipv4_pkg;

    localparam int          ETH_HDR_BYTES  = 14;
    localparam int          IPV4_HDR_BYTES = 20;
    localparam int          HDR_BYTES      = ETH_HDR_BYTES + IPV4_HDR_BYTES;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] ip_length;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSUM,
        ST_HDR,
        ST_PAY
    } state_t;

endpackage

// File: rtl/ipv4_checksum_gen.sv
// ipv4_checksum_gen
//   Two-stage IPv4 header checksum (IHL=5, checksum field taken as zero).
//   req sampled at cycle N -> valid/chksum presented at cycle N+2.
// Ports
//   clk, sreset         clock, synchronous active-high reset
//   req                 start pulse; fields must be stable while req is high
//   tos .. dst_ip       IPv4 header fields that feed the sum
//   valid               1-cycle pulse, chksum is valid
//   chksum              one's-complement header checksum
module ipv4_checksum_gen
    import ipv4_pkg::*;
(
    input  logic        clk,
    input  logic        sreset,
    input  logic        req,
    input  logic [7:0]  tos,
    input  logic [15:0] ip_length,
    input  logic [15:0] id,
    input  logic [15:0] flags_frag,
    input  logic [7:0]  ttl,
    input  logic [7:0]  proto,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic        valid,
    output logic [15:0] chksum
);

    // Ten 16-bit words sum to at most 0x9FFF6, so 20 bits never overflow.
    logic [19:0] sum_d, sum_q;
    logic        sum_vld_d, sum_vld_q;
    logic [15:0] chksum_d, chksum_q;
    logic        valid_d, valid_q;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum_d = 20'({IPV4_VER_IHL, tos}) + 20'(ip_length) + 20'(id)
              + 20'(flags_frag) + 20'({ttl, proto})
              + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
              + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
        sum_vld_d = req;

        // Two end-around-carry folds suffice: the first leaves at most 0x10008.
        fold1    = 17'(sum_q[15:0]) + 17'(sum_q[19:16]);
        fold2    = fold1[15:0] + 16'(fold1[16]);
        chksum_d = ~fold2;
        valid_d  = sum_vld_q;
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            chksum_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            chksum_q  <= chksum_d;
            valid_q   <= valid_d;
        end
    end

    assign valid  = valid_q;
    assign chksum = chksum_q;

endmodule

// File: rtl/ipv4_hdr_inserter.sv
// ipv4_hdr_inserter
//   Prepends a 34-byte Ethernet II + IPv4 header to a byte-wide AXI-Stream
//   payload and forwards the payload up to its tlast.
//
//   state | meaning
//   IDLE  | waiting for a header request (hdr_ready=1)
//   CSUM  | checksum requested, waiting for its result
//   HDR   | serializing header bytes 0..33
//   PAY   | passing payload through until tlast
//
// Ports
//   clk, sreset                 clock, synchronous active-high reset
//   hdr_valid/hdr_ready/hdr     header request handshake and fields
//   s_axis_*                    payload stream in
//   m_axis_*                    framed stream out
//   hdr_err                     pulse: request rejected (ip_length < 20)
//   len_err                     pulse: payload length disagrees with ip_length
//   frames_sent                 wrapping count of completed frames
module ipv4_hdr_inserter
    import ipv4_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  ipv4_hdr_fields_t hdr,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             hdr_err,
    output logic             len_err,
    output logic [CNT_W-1:0] frames_sent
);

    localparam logic [5:0]  LAST_IDX = 6'(HDR_BYTES - 1);
    localparam logic [15:0] MIN_LEN  = 16'(IPV4_HDR_BYTES);

    state_t           state_d, state_q;
    logic [5:0]       idx_d, idx_q;
    ipv4_hdr_fields_t fields_d, fields_q;
    logic [15:0]      cs_d, cs_q;
    logic [15:0]      cnt_d, cnt_q;
    logic             req_d, req_q;
    logic             hdr_err_d, hdr_err_q;
    logic             len_err_d, len_err_q;
    logic [CNT_W-1:0] frames_d, frames_q;

    logic        cs_valid;
    logic [15:0] cs_value;
    logic [15:0] cnt_inc;
    logic        hdr_only;

    // Header as one 272-bit word, byte 0 in the top bits.
    function automatic logic [7:0] hdr_byte(input ipv4_hdr_fields_t f,
                                            input logic [15:0] cs,
                                            input logic [5:0] idx);
        logic [HDR_BYTES*8-1:0] flat;
        flat = {f.dest_mac, f.src_mac, f.eth_type, IPV4_VER_IHL, f.dscp, f.ecn,
                f.ip_length, f.id, f.flags, f.frag, f.ttl, f.proto, cs,
                f.src_ip, f.dst_ip};
        return 8'(flat >> {LAST_IDX - idx, 3'b000});
    endfunction

    ipv4_checksum_gen u_chksum (
        .clk        (clk),
        .sreset     (sreset),
        .req        (req_q),
        .tos        ({fields_q.dscp, fields_q.ecn}),
        .ip_length  (fields_q.ip_length),
        .id         (fields_q.id),
        .flags_frag ({fields_q.flags, fields_q.frag}),
        .ttl        (fields_q.ttl),
        .proto      (fields_q.proto),
        .src_ip     (fields_q.src_ip),
        .dst_ip     (fields_q.dst_ip),
        .valid      (cs_valid),
        .chksum     (cs_value)
    );

    assign hdr_only = (fields_q.ip_length == MIN_LEN);
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        hdr_ready     = (state_q == ST_IDLE);
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        case (state_q)
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte(fields_q, cs_q, idx_q);
                m_axis_tlast  = (idx_q == LAST_IDX) && hdr_only;
            end
            ST_PAY: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fields_d  = fields_q;
        cs_d      = cs_q;
        cnt_d     = cnt_q;
        req_d     = 1'b0;
        hdr_err_d = 1'b0;
        len_err_d = 1'b0;
        frames_d  = frames_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_valid) begin
                    fields_d = hdr;
                    if (hdr.ip_length < MIN_LEN) begin
                        hdr_err_d = 1'b1;
                    end else begin
                        state_d = ST_CSUM;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                if (cs_valid) begin
                    cs_d    = cs_value;
                    idx_d   = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        if (hdr_only) begin
                            frames_d = frames_q + 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_PAY;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_PAY: begin
                if (s_axis_tvalid && m_axis_tready) begin
                    cnt_d = cnt_inc;
                    if (s_axis_tlast) begin
                        len_err_d = (cnt_inc != (fields_q.ip_length - MIN_LEN));
                        frames_d  = frames_q + 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            fields_q  <= '0;
            cs_q      <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            hdr_err_q <= 1'b0;
            len_err_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fields_q  <= fields_d;
            cs_q      <= cs_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            hdr_err_q <= hdr_err_d;
            len_err_q <= len_err_d;
            frames_q  <= frames_d;
        end
    end

    assign hdr_err     = hdr_err_q;
    assign len_err     = len_err_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_ipv4_hdr_inserter.sv
// tb_ipv4_hdr_inserter
//   Directed scenarios for the IPv4 header inserter; each task drives its
//   own stimulus and compares the captured stream against bench-built bytes.
module tb_ipv4_hdr_inserter;
    import ipv4_pkg::*;

    logic             clk = 1'b0;
    logic             sreset = 1'b1;
    logic             hdr_valid = 1'b0;
    logic             hdr_ready;
    ipv4_hdr_fields_t hdr = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [7:0]       s_axis_tdata = 8'h00;
    logic             s_axis_tlast = 1'b0;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tlast;
    logic             hdr_err;
    logic             len_err;
    logic [31:0]      frames_sent;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    int   hdr_err_cnt, len_err_cnt, len_err_at, stall_viol;
    bit   s_tready_seen, tv_seen, stall_pend;
    logic [8:0] stall_word;

    ipv4_hdr_inserter #(.CNT_W(32)) dut (
        .clk           (clk),
        .sreset        (sreset),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr           (hdr),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .hdr_err       (hdr_err),
        .len_err       (len_err),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sreset) begin
            stall_pend = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back({m_axis_tlast, m_axis_tdata});
            if (hdr_err) hdr_err_cnt++;
            if (len_err) begin
                len_err_cnt++;
                len_err_at = out_q.size();
            end
            if (s_axis_tready) s_tready_seen = 1'b1;
            if (m_axis_tvalid) tv_seen = 1'b1;
            if (stall_pend && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== stall_word))
                stall_viol++;
            stall_pend = m_axis_tvalid && !m_axis_tready;
            stall_word = {m_axis_tlast, m_axis_tdata};
        end
    end

    function automatic logic [7:0] pay_byte(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    function automatic ipv4_hdr_fields_t mk_hdr(input logic [15:0] len, input logic [15:0] id,
                                                input logic [5:0] dscp);
        ipv4_hdr_fields_t h;
        h.dest_mac  = 48'h0011_2233_4455;
        h.src_mac   = 48'h0A0B_0C0D_0E0F;
        h.eth_type  = ETHERTYPE_IPV4;
        h.dscp      = dscp;
        h.ecn       = 2'b01;
        h.ip_length = len;
        h.id        = id;
        h.flags     = 3'b010;
        h.frag      = 13'h0005;
        h.ttl       = 8'h40;
        h.proto     = 8'h06;
        h.src_ip    = 32'h0A00_0001;
        h.dst_ip    = 32'h0A00_00FE;
        return h;
    endfunction

    function automatic logic [15:0] model_csum(input ipv4_hdr_fields_t h);
        int unsigned s;
        s = {8'h45, h.dscp, h.ecn} + h.ip_length + h.id + {h.flags, h.frag}
          + {h.ttl, h.proto} + h.src_ip[31:16] + h.src_ip[15:0]
          + h.dst_ip[31:16] + h.dst_ip[15:0];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~16'(s);
    endfunction

    function automatic void build_exp(input ipv4_hdr_fields_t h, input int npay);
        logic [15:0] cs;
        cs = model_csum(h);
        exp_q.delete();
        for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, h.dest_mac[8*i +: 8]});
        for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, h.src_mac[8*i +: 8]});
        exp_q.push_back({1'b0, h.eth_type[15:8]});
        exp_q.push_back({1'b0, h.eth_type[7:0]});
        exp_q.push_back({1'b0, 8'h45});
        exp_q.push_back({1'b0, h.dscp, h.ecn});
        exp_q.push_back({1'b0, h.ip_length[15:8]});
        exp_q.push_back({1'b0, h.ip_length[7:0]});
        exp_q.push_back({1'b0, h.id[15:8]});
        exp_q.push_back({1'b0, h.id[7:0]});
        exp_q.push_back({1'b0, h.flags, h.frag[12:8]});
        exp_q.push_back({1'b0, h.frag[7:0]});
        exp_q.push_back({1'b0, h.ttl});
        exp_q.push_back({1'b0, h.proto});
        exp_q.push_back({1'b0, cs[15:8]});
        exp_q.push_back({1'b0, cs[7:0]});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, h.src_ip[8*i +: 8]});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, h.dst_ip[8*i +: 8]});
        for (int i = 0; i < npay; i++) exp_q.push_back({1'b0, pay_byte(i)});
        exp_q[exp_q.size()-1] = exp_q[exp_q.size()-1] | 9'h100;
    endfunction

    task automatic clear_mon();
        out_q.delete();
        hdr_err_cnt   = 0;
        len_err_cnt   = 0;
        len_err_at    = -1;
        stall_viol    = 0;
        s_tready_seen = 1'b0;
        tv_seen       = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle. Returns when the final tlast
    // has been handshaked (done=1), on timeout, or once payload byte
    // abort_at is being presented (abort_at >= 0).
    task automatic send_frame(input ipv4_hdr_fields_t h, input int npay, input bit bp,
                              input int abort_at, output int lat, output bit done);
        int pay_idx = 0;
        int cyc = 0;
        bit hs, last_hs, seen_tv = 1'b0, stop = 1'b0;
        lat  = -1;
        done = 1'b0;
        hdr = h;
        hdr_valid = 1'b1;
        s_axis_tvalid = (npay > 0);
        s_axis_tdata  = pay_byte(0);
        s_axis_tlast  = (npay == 1);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        while (!done && !stop && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!seen_tv && m_axis_tvalid) begin
                seen_tv = 1'b1;
                lat = cyc;
            end
            hs      = s_axis_tvalid && s_axis_tready;
            last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            @(posedge clk); #1;
            if (hs) pay_idx++;
            if (last_hs) done = 1'b1;
            s_axis_tvalid = (pay_idx < npay) && !done;
            s_axis_tdata  = pay_byte(pay_idx);
            s_axis_tlast  = (pay_idx == npay - 1);
            m_axis_tready = bp ? ~m_axis_tready : 1'b1;
            if (abort_at >= 0 && pay_idx == abort_at) stop = 1'b1;
        end
        if (!stop) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            m_axis_tready = 1'b1;
        end
    endtask

    task automatic test_reset();
        sreset = 1'b1;
        repeat (3) @(posedge clk);
        #1 sreset = 1'b0;
        @(negedge clk);
        checks++; if (hdr_ready !== 1'b1)     begin errors++; $display("FAIL reset_hdr_ready got=%b exp=1", hdr_ready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got=%b exp=0", s_axis_tready); end
        checks++; if (hdr_err !== 1'b0)       begin errors++; $display("FAIL reset_hdr_err got=%b exp=0", hdr_err); end
        checks++; if (len_err !== 1'b0)       begin errors++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
        checks++; if (frames_sent !== 32'd0)  begin errors++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int lat, mism;
        bit done;
        clear_mon();
        send_frame(mk_hdr(16'd60, 16'h0101, 6'd0), 40, 1'b0, 10, lat, done);
        sreset = 1'b1;
        @(posedge clk); #1;
        sreset = 1'b0;
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (hdr_ready !== 1'b1)     begin errors++; $display("FAIL midreset_idle got=%b exp=1", hdr_ready); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL midreset_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        build_exp(mk_hdr(16'd45, 16'h0202, 6'h0A), 25);
        send_frame(mk_hdr(16'd45, 16'h0202, 6'h0A), 25, 1'b0, -1, lat, done);
        exp_frames++;
        @(negedge clk);
        mism = 0;
        foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
        checks++; if (!done) begin errors++; $display("FAIL postreset_timeout got=0 exp=1"); end
        checks++; if (out_q.size() !== exp_q.size() || mism !== 0) begin errors++; $display("FAIL postreset_stream got_len=%0d mism=%0d exp_len=%0d mism=0", out_q.size(), mism, exp_q.size()); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL postreset_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    task automatic test_rfc_vector();
        ipv4_hdr_fields_t h;
        int lat, mism, lasts;
        bit done;
        h = '0;
        h.dest_mac  = 48'h0011_2233_4455;
        h.src_mac   = 48'h0A0B_0C0D_0E0F;
        h.eth_type  = ETHERTYPE_IPV4;
        h.ip_length = 16'h0073;
        h.flags     = 3'b010;
        h.ttl       = 8'h40;
        h.proto     = 8'h11;
        h.src_ip    = 32'hC0A8_0001;
        h.dst_ip    = 32'hC0A8_00C7;
        clear_mon();
        build_exp(h, 95);
        send_frame(h, 95, 1'b0, -1, lat, done);
        exp_frames++;
        @(negedge clk);
        mism = 0;
        foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
        lasts = 0;
        foreach (out_q[i]) if (out_q[i][8]) lasts++;
        checks++; if (!done) begin errors++; $display("FAIL rfc_timeout got=0 exp=1"); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL rfc_latency got=%0d exp=4", lat); end
        checks++; if (out_q.size() !== 129) begin errors++; $display("FAIL rfc_len got=%0d exp=129", out_q.size()); end
        checks++; if (out_q.size() < 26 || out_q[24] !== 9'h0B8 || out_q[25] !== 9'h061)
            begin errors++; $display("FAIL rfc_checksum got=%h%h exp=b861", out_q.size() > 24 ? out_q[24][7:0] : 8'hxx, out_q.size() > 25 ? out_q[25][7:0] : 8'hxx); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL rfc_stream got_mism=%0d exp=0", mism); end
        checks++; if (lasts !== 1 || out_q.size() == 0 || out_q[out_q.size()-1][8] !== 1'b1) begin errors++; $display("FAIL rfc_tlast got_count=%0d exp=1 on final byte", lasts); end
        checks++; if (len_err_cnt !== 0 || hdr_err_cnt !== 0) begin errors++; $display("FAIL rfc_errs got_len=%0d got_hdr=%0d exp=0", len_err_cnt, hdr_err_cnt); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL rfc_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        ipv4_hdr_fields_t h;
        int lat, mism;
        bit done;
        h = mk_hdr(16'd50, 16'hBEEF, 6'h2E);
        clear_mon();
        build_exp(h, 30);
        send_frame(h, 30, 1'b1, -1, lat, done);
        exp_frames++;
        @(negedge clk);
        mism = 0;
        foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
        checks++; if (!done) begin errors++; $display("FAIL bp_timeout got=0 exp=1"); end
        checks++; if (out_q.size() !== 64 || mism !== 0) begin errors++; $display("FAIL bp_stream got_len=%0d mism=%0d exp_len=64 mism=0", out_q.size(), mism); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL bp_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    task automatic test_hdr_only();
        ipv4_hdr_fields_t h;
        int lat, mism;
        bit done;
        h = mk_hdr(16'd20, 16'h0033, 6'h01);
        clear_mon();
        build_exp(h, 0);
        send_frame(h, 0, 1'b0, -1, lat, done);
        exp_frames++;
        @(negedge clk);
        mism = 0;
        foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
        checks++; if (!done) begin errors++; $display("FAIL hdronly_timeout got=0 exp=1"); end
        checks++; if (out_q.size() !== 34 || mism !== 0) begin errors++; $display("FAIL hdronly_stream got_len=%0d mism=%0d exp_len=34 mism=0", out_q.size(), mism); end
        checks++; if (out_q.size() < 34 || out_q[33][8] !== 1'b1) begin errors++; $display("FAIL hdronly_tlast33 got=0 exp=1"); end
        checks++; if (s_tready_seen !== 1'b0) begin errors++; $display("FAIL hdronly_s_tready got=%b exp=0", s_tready_seen); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL hdronly_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    task automatic test_short_hdr();
        clear_mon();
        hdr = mk_hdr(16'd19, 16'h0044, 6'h00);
        hdr_valid = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        @(negedge clk);
        checks++; if (hdr_err !== 1'b1)   begin errors++; $display("FAIL short_hdr_err got=%b exp=1", hdr_err); end
        checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL short_hdr_ready got=%b exp=1", hdr_ready); end
        repeat (8) @(negedge clk);
        checks++; if (hdr_err_cnt !== 1) begin errors++; $display("FAIL short_hdr_pulses got=%0d exp=1", hdr_err_cnt); end
        checks++; if (tv_seen !== 1'b0)  begin errors++; $display("FAIL short_hdr_tvalid got=%b exp=0", tv_seen); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL short_hdr_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    task automatic test_len_err();
        ipv4_hdr_fields_t h;
        int lat, mism;
        bit done;
        h = mk_hdr(16'd100, 16'h0555, 6'h10);
        clear_mon();
        build_exp(h, 70);
        send_frame(h, 70, 1'b0, -1, lat, done);
        exp_frames++;
        repeat (3) @(negedge clk);
        mism = 0;
        foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
        checks++; if (!done) begin errors++; $display("FAIL lenerr_timeout got=0 exp=1"); end
        checks++; if (out_q.size() !== 104 || mism !== 0) begin errors++; $display("FAIL lenerr_stream got_len=%0d mism=%0d exp_len=104 mism=0", out_q.size(), mism); end
        checks++; if (len_err_cnt !== 1) begin errors++; $display("FAIL lenerr_pulses got=%0d exp=1", len_err_cnt); end
        checks++; if (len_err_at !== 104) begin errors++; $display("FAIL lenerr_timing got_after=%0d exp_after=104", len_err_at); end
        checks++; if (frames_sent !== 32'(exp_frames)) begin errors++; $display("FAIL lenerr_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_rfc_vector();
        test_backpressure();
        test_hdr_only();
        test_short_hdr();
        test_len_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
